div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Request/response front-end for the 32-bit iterative unsigned divider core (`Divide`).
- Accepts signed or unsigned divide requests over a valid/ready handshake and converts signed operands to magnitudes.
- Sequences the core's level-sensitive start/ok protocol, applies sign correction to quotient and remainder, and returns results over a valid/ready handshake.
- Handles divide-by-zero locally without starting the core.

Parameters:
WIDTH, 32, operand/result width; must equal the divider core width (fixed 32 in this design).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset); also drives the divider core reset through an inverter at integration
req_valid  input  1  request valid
req_ready  output  1  controller can accept a request
req_signed  input  1  1 = two's-complement divide, 0 = unsigned
req_dividend  input  WIDTH  dividend
req_divisor  input  WIDTH  divisor
div_start  output  1  to core start; must stay high for the whole operation
div_a  output  WIDTH  to core A (dividend magnitude)
div_b  output  WIDTH  to core B (divisor magnitude)
div_q  input  WIDTH  from core D (unsigned quotient)
div_r  input  WIDTH  from core R (unsigned remainder)
div_ok  input  1  from core ok (1 = core idle / result ready)
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_quot  output  WIDTH  final quotient
rsp_rem  output  WIDTH  final remainder
rsp_err  output  1  1 = divide by zero

Behaviour:
- Reset (reset=0, async): state=IDLE; req_ready=1, div_start=0, div_a=0, div_b=0, rsp_valid=0, rsp_quot=0, rsp_rem=0, rsp_err=0. Takes effect immediately, including mid-operation. The core is co-reset, so no stale run survives.
- States: IDLE, LOAD, RUN, DONE.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid & req_ready.
- On accept with divisor==0:
  - Go to DONE directly; core untouched.
  - rsp_quot = all ones; rsp_rem = dividend unmodified; rsp_err=1.
  - Applies to signed and unsigned requests alike.
- On accept with divisor!=0:
  - Register div_a = |dividend| and div_b = |divisor| (magnitude only when req_signed=1 and MSB=1; otherwise the raw value).
  - Register neg_q = signed & (dividend MSB ^ divisor MSB) and neg_r = signed & dividend MSB.
  - Go to LOAD.
- LOAD (exactly 1 cycle): div_start=1. The core loads on this edge, then go to RUN. div_ok is ignored in LOAD because it is still 1 from idle.
- RUN, div_start combinational:
  - div_start = ~div_ok. It stays high through the core's 32 iteration edges.
  - In the first RUN cycle where div_ok=1, div_start must already be 0 in that same cycle; otherwise the core reloads.
- RUN exit (edge where div_ok=1):
  - rsp_quot = neg_q ? -div_q : div_q; rsp_rem = neg_r ? -div_r : div_r; rsp_err=0.
  - Go to DONE.
- Latency:
  - rsp_valid is high in the 34th cycle after the accept edge for a nonzero divisor.
  - rsp_valid is high the cycle after accept for a zero divisor.
- DONE:
  - rsp_valid=1 with quot/rem/err held stable until rsp_ready=1.
  - On the handshake edge go to IDLE and drop rsp_valid. If rsp_ready is already high on DONE entry, that cycle's edge completes it.
  - The next request is accepted no earlier than the cycle after rsp handshake; no back-to-back overlap.
- Signed overflow (-2^31 / -1): magnitudes give 0x80000000/1; negation is not applied (neg_q=0). Result quot=0x80000000, rem=0. Must not hang or raise err.
- Arithmetic: all negation is two's-complement modulo 2^WIDTH. Remainder sign follows the dividend; quotient truncates toward zero.
- req_* inputs are don't-care outside the accept edge. div_a/div_b hold until the next accept.

Test Plan:
- Unsigned 100/7, rsp_ready=1 -> after 34 cycles rsp_quot=14, rsp_rem=2, rsp_err=0; div_start high exactly 33 consecutive cycles, then 0.
- Signed -100/7 -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2). Signed 100/-7 -> quot=-14, rem=2. Signed -100/-7 -> quot=14, rem=-2.
- Divisor 0, dividend 0x12345678 (signed and unsigned) -> rsp_valid next cycle, quot=0xFFFFFFFF, rem=0x12345678, err=1; div_start never asserted.
- Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0, err=0. Unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> outputs stable, req_ready=0, no second core start; release -> IDLE, next request 50/5 returns quot=10, rem=0.
- Assert reset=0 mid-RUN (cycle 15) -> all outputs at reset values immediately; after release, a fresh 9/4 gives quot=2, rem=1 with nominal latency.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Request/response front-end for the 32-bit iterative unsigned divider core.
// Converts signed requests to magnitudes, sequences the core and sign-corrects results.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_ok,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quot,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             div_zero_s;
    logic             finish_s;
    logic             div_start_s;
    logic [WIDTH-1:0] div_a_r;
    logic [WIDTH-1:0] div_b_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             rsp_valid_r;
    logic             req_ready_r;
    logic [WIDTH-1:0] rsp_quot_r;
    logic [WIDTH-1:0] rsp_rem_r;
    logic             rsp_err_r;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] val);
        return ~val + ONE_C;
    endfunction

    // Most-negative value maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] val,
                                                   input logic             is_signed);
        if (is_signed && val[WIDTH-1]) begin
            return twos_neg(val);
        end else begin
            return val;
        end
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_divisor == ZERO_C) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: state_next_s = RUN;
            RUN: begin
                if (div_ok) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Core start and transaction strobes; start must fall in the same cycle ok rises
    always_comb begin
        accept_s    = 1'b0;
        div_zero_s  = 1'b0;
        finish_s    = 1'b0;
        div_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s   = req_valid;
                div_zero_s = (req_divisor == ZERO_C);
            end
            LOAD: div_start_s = 1'b1;
            RUN: begin
                div_start_s = ~div_ok;
                finish_s    = div_ok;
            end
            DONE: div_start_s = 1'b0;
            default: div_start_s = 1'b0;
        endcase
    end

    // Operand magnitudes and sign-correction flags captured at accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_a_r <= ZERO_C;
            div_b_r <= ZERO_C;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s && !div_zero_s) begin
            div_a_r <= magnitude(req_dividend, req_signed);
            div_b_r <= magnitude(req_divisor, req_signed);
            neg_q_r <= req_signed & (req_dividend[WIDTH-1] ^ req_divisor[WIDTH-1]);
            neg_r_r <= req_signed & req_dividend[WIDTH-1];
        end else begin
            div_a_r <= div_a_r;
            div_b_r <= div_b_r;
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end

    // Response payload: divide-by-zero handled locally, otherwise sign-corrected core result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_quot_r <= ZERO_C;
            rsp_rem_r  <= ZERO_C;
            rsp_err_r  <= 1'b0;
        end else if (accept_s && div_zero_s) begin
            rsp_quot_r <= ONES_C;
            rsp_rem_r  <= req_dividend;
            rsp_err_r  <= 1'b1;
        end else if (finish_s) begin
            rsp_quot_r <= neg_q_r ? twos_neg(div_q) : div_q;
            rsp_rem_r  <= neg_r_r ? twos_neg(div_r) : div_r;
            rsp_err_r  <= 1'b0;
        end else begin
            rsp_quot_r <= rsp_quot_r;
            rsp_rem_r  <= rsp_rem_r;
            rsp_err_r  <= rsp_err_r;
        end
    end

    // Handshake flags registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            rsp_valid_r <= (state_next_s == DONE);
            req_ready_r <= (state_next_s == IDLE);
        end
    end

    assign req_ready = req_ready_r;
    assign div_start = div_start_s;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_quot  = rsp_quot_r;
    assign rsp_rem   = rsp_rem_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl with a behavioural divider core and arithmetic reference.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic [31:0] req_dividend = 32'd0;
    logic [31:0] req_divisor = 32'd0;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_ok;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_quot;
    logic [31:0] rsp_rem;
    logic        rsp_err;

    int vecs = 0;
    int fails = 0;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_ok(div_ok),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural core: loads on start while idle, ok low for 32 iteration edges.
    logic        core_ok;
    logic [31:0] core_a, core_b, core_q, core_r;
    int          core_cnt;
    int          load_cnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_ok  <= 1'b1;
            core_cnt <= 0;
            core_q   <= 32'd0;
            core_r   <= 32'd0;
        end else if (core_ok) begin
            if (div_start) begin
                core_a   <= div_a;
                core_b   <= div_b;
                core_ok  <= 1'b0;
                core_cnt <= 0;
                load_cnt <= load_cnt + 1;
            end
        end else begin
            if (core_cnt == 31) begin
                core_ok <= 1'b1;
                core_q  <= core_a / core_b;
                core_r  <= core_a % core_b;
            end
            core_cnt <= core_cnt + 1;
        end
    end

    assign div_ok = core_ok;
    assign div_q  = core_q;
    assign div_r  = core_r;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic e);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; e = 1'b1;
        end else if (sg) begin
            sa = $signed(a); sb = $signed(b);
            q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
        end else begin
            q = a / b; r = a % b; e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] ref_mag(input logic sg, input logic [31:0] v);
        longint sv;
        sv = sg ? longint'($signed(v)) : longint'(v);
        return 32'(sv < 0 ? -sv : sv);
    endfunction

    task automatic run_txn(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int hold);
        logic [31:0] eq, er;
        logic        ee;
        int          edges, starts, loads0;
        ref_div(sg, a, b, eq, er, ee);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_signed = sg; req_dividend = a; req_divisor = b;
        rsp_ready = (hold == 0);
        loads0 = load_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_dividend = $urandom; req_divisor = $urandom;
        req_signed = 1'($urandom_range(0, 1));
        edges = 0; starts = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid || edges > 100) break;
            if (div_start) starts++;
            @(posedge clk);
            edges++;
        end
        chk("latency_edges", 32'(edges), (b == 32'd0) ? 32'd0 : 32'd34);
        chk("start_cycles", 32'(starts), (b == 32'd0) ? 32'd0 : 32'd33);
        chk("rsp_quot", rsp_quot, eq);
        chk("rsp_rem", rsp_rem, er);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (b != 32'd0) begin
            chk("div_a_mag", div_a, ref_mag(sg, a));
            chk("div_b_mag", div_b, ref_mag(sg, b));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_quot", rsp_quot, eq);
            chk("hold_rem", rsp_rem, er);
            chk("hold_err", 32'(rsp_err), 32'(ee));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_div_start", 32'(div_start), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
        chk("core_loads", 32'(load_cnt - loads0), (b == 32'd0) ? 32'd0 : 32'd1);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_quot", rsp_quot, 32'd0);
        chk("rst_rsp_rem", rsp_rem, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic        sg;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;

        run_txn(1'b0, 32'd100, 32'd7, 0);
        run_txn(1'b1, -32'sd100, 32'd7, 0);
        run_txn(1'b1, 32'd100, -32'sd7, 0);
        run_txn(1'b1, -32'sd100, -32'sd7, 0);
        run_txn(1'b0, 32'h1234_5678, 32'd0, 0);
        run_txn(1'b1, 32'h1234_5678, 32'd0, 0);
        run_txn(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_txn(1'b0, 32'd1000, 32'd9, 10);
        run_txn(1'b0, 32'd50, 32'd5, 0);

        // Reset asserted mid-run, 15 cycles after accept
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        run_txn(1'b0, 32'd9, 32'd4, 0);

        for (int n = 0; n < 25; n++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_txn(sg, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
